// File: rtl/fc_layer_sequencer.sv
// fc_layer_sequencer
//   Runs a NUM_LAYERS-deep 16x16 MLP on one shared fully-connected engine.
//   Each layer's 256 weights and 16 biases are streamed from the weight ROM
//   into a local register file. The engine is then started and its outputs
//   are captured. Hidden-layer outputs pass through ReLU and are fed back as
//   the next layer's input. After the last layer the raw outputs are scanned
//   for the argmax, and the vector and class are presented over valid/ready.
// Ports
//   clk, rstN                      clock, async active-low reset
//   in_valid/in_ready/in_vector    layer-0 activations (16 x s16)
//   mem_rd_en/mem_addr/mem_rd_data ROM read port, data one cycle after strobe
//   fc_input/fc_weights/fc_biases  engine operands, held START..CAPTURE
//   fc_valid_in/fc_output/fc_valid_out  engine start pulse, results, done
//   out_valid/out_ready/out_vector/out_class  result handshake
//   busy, timeout_err              status
//
// state     | meaning
// S_IDLE    | waiting for an input vector
// S_LOAD    | streaming 272 ROM words into the weight/bias register file
// S_START   | one-cycle engine start, arms the timeout counter
// S_WAIT    | waiting for a rising edge of fc_valid_out
// S_CAPTURE | hidden layer: ReLU and feed back; last layer: keep raw outputs
// S_ARGMAX  | 16-cycle sequential argmax over out_vector
// S_OUT     | result held until out_ready
module fc_layer_sequencer #(
  parameter int NUM_LAYERS     = 2,
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [15:0][15:0]    in_vector,
  output logic                 mem_rd_en,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [15:0]          mem_rd_data,
  output logic [15:0][15:0]    fc_input,
  output logic [255:0][15:0]   fc_weights,
  output logic [15:0][15:0]    fc_biases,
  output logic                 fc_valid_in,
  input  logic [15:0][15:0]    fc_output,
  input  logic                 fc_valid_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0][15:0]    out_vector,
  output logic [3:0]           out_class,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int LW          = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int TW          = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int LAYER_WORDS = 272;
  localparam logic [LW-1:0] LAST_LAYER = LW'(NUM_LAYERS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT, S_CAPTURE, S_ARGMAX, S_OUT
  } state_t;

  state_t                state_q, state_d;
  logic [LW-1:0]         layer_q, layer_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  // Shared step counter: ROM word index in LOAD, element index in ARGMAX.
  logic [8:0]            cnt_q, cnt_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  fvo_prev_q, fvo_prev_d;
  logic signed [15:0]    best_val_q, best_val_d;
  logic                  timeout_err_q, timeout_err_d;
  logic [15:0][15:0]     fc_input_q, fc_input_d;
  logic [255:0][15:0]    fc_weights_q, fc_weights_d;
  logic [15:0][15:0]     fc_biases_q, fc_biases_d;
  logic [15:0][15:0]     out_vector_q, out_vector_d;
  logic [3:0]            out_class_q, out_class_d;
  logic [8:0]            wr_idx;
  logic                  fvo_edge;

  assign fvo_edge    = fc_valid_out & ~fvo_prev_q;
  assign mem_rd_en   = (state_q == S_LOAD) && (cnt_q < 9'(LAYER_WORDS));
  assign mem_addr    = mem_rd_en ? base_q + ADDR_W'(cnt_q) : '0;
  assign in_ready    = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign fc_valid_in = (state_q == S_START);
  assign out_valid   = (state_q == S_OUT);
  assign timeout_err = timeout_err_q;
  assign fc_input    = fc_input_q;
  assign fc_weights  = fc_weights_q;
  assign fc_biases   = fc_biases_q;
  assign out_vector  = out_vector_q;
  assign out_class   = out_class_q;

  always_comb begin
    state_d       = state_q;
    layer_d       = layer_q;
    base_d        = base_q;
    cnt_d         = cnt_q;
    tmo_d         = tmo_q;
    fvo_prev_d    = fc_valid_out;
    best_val_d    = best_val_q;
    timeout_err_d = 1'b0;
    fc_input_d    = fc_input_q;
    fc_weights_d  = fc_weights_q;
    fc_biases_d   = fc_biases_q;
    out_vector_d  = out_vector_q;
    out_class_d   = out_class_q;
    wr_idx        = cnt_q - 9'd1;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          fc_input_d = in_vector;
          layer_d    = '0;
          base_d     = '0;
          cnt_d      = '0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        // Data read in cycle k arrives in cycle k+1, so writes lag by one.
        if (cnt_q != 9'd0) begin
          if (wr_idx < 9'd256) fc_weights_d[wr_idx[7:0]] = mem_rd_data;
          else                 fc_biases_d[wr_idx[3:0]]  = mem_rd_data;
        end
        if (cnt_q == 9'(LAYER_WORDS)) begin
          cnt_d   = '0;
          state_d = S_START;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      S_START: begin
        tmo_d   = TW'(TIMEOUT_CYCLES - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (fvo_edge) begin
          state_d = S_CAPTURE;
        end else if (tmo_q == '0) begin
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          tmo_d = tmo_q - TW'(1);
        end
      end
      S_CAPTURE: begin
        cnt_d = '0;
        if (layer_q == LAST_LAYER) begin
          out_vector_d = fc_output;
          state_d      = S_ARGMAX;
        end else begin
          for (int j = 0; j < 16; j++)
            fc_input_d[j] = fc_output[j][15] ? 16'd0 : fc_output[j];
          layer_d = layer_q + LW'(1);
          base_d  = base_q + ADDR_W'(LAYER_WORDS);
          state_d = S_LOAD;
        end
      end
      S_ARGMAX: begin
        // Strict '>' keeps the lowest index on ties.
        if (cnt_q[3:0] == 4'd0 || $signed(out_vector_q[cnt_q[3:0]]) > best_val_q) begin
          best_val_d  = $signed(out_vector_q[cnt_q[3:0]]);
          out_class_d = cnt_q[3:0];
        end
        if (cnt_q[3:0] == 4'd15) state_d = S_OUT;
        else                     cnt_d   = cnt_q + 9'd1;
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q       <= S_IDLE;
      layer_q       <= '0;
      base_q        <= '0;
      cnt_q         <= '0;
      tmo_q         <= '0;
      fvo_prev_q    <= 1'b0;
      best_val_q    <= '0;
      timeout_err_q <= 1'b0;
      fc_input_q    <= '0;
      fc_weights_q  <= '0;
      fc_biases_q   <= '0;
      out_vector_q  <= '0;
      out_class_q   <= '0;
    end else begin
      state_q       <= state_d;
      layer_q       <= layer_d;
      base_q        <= base_d;
      cnt_q         <= cnt_d;
      tmo_q         <= tmo_d;
      fvo_prev_q    <= fvo_prev_d;
      best_val_q    <= best_val_d;
      timeout_err_q <= timeout_err_d;
      fc_input_q    <= fc_input_d;
      fc_weights_q  <= fc_weights_d;
      fc_biases_q   <= fc_biases_d;
      out_vector_q  <= out_vector_d;
      out_class_q   <= out_class_d;
    end
  end

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// tb_fc_layer_sequencer
//   Directed and randomized checks of fc_layer_sequencer (2 layers) against a
//   reference MLP computed from the ROM contents. Includes a stand-in engine
//   and a ROM model with one-cycle read latency.
module tb_fc_layer_sequencer;

  localparam int NL  = 2;
  localparam int AW  = 10;
  localparam int TMO = 1024;

  logic                clk = 1'b0;
  logic                rstN = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [15:0][15:0]   in_vector = '0;
  logic                mem_rd_en;
  logic [AW-1:0]       mem_addr;
  logic [15:0]         mem_rd_data = '0;
  logic [15:0][15:0]   fc_input;
  logic [255:0][15:0]  fc_weights;
  logic [15:0][15:0]   fc_biases;
  logic                fc_valid_in;
  logic [15:0][15:0]   fc_output;
  logic                fc_valid_out;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [15:0][15:0]   out_vector;
  logic [3:0]          out_class;
  logic                busy;
  logic                timeout_err;

  fc_layer_sequencer #(.NUM_LAYERS(NL), .ADDR_W(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rstN(rstN),
    .in_valid(in_valid), .in_ready(in_ready), .in_vector(in_vector),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .fc_input(fc_input), .fc_weights(fc_weights), .fc_biases(fc_biases),
    .fc_valid_in(fc_valid_in), .fc_output(fc_output), .fc_valid_out(fc_valid_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_vector(out_vector),
    .out_class(out_class), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [15:0] rom [1024];
  logic [AW-1:0] addr_log [$];
  logic [15:0] w255_log [$];
  logic [15:0] b15_log [$];
  int last_start = 0, tmo_cnt = 0, tmo_cyc = 0, ov_cnt = 0;
  int eng_lat = 3;
  bit eng_hold = 1'b0;
  logic [15:0] xv [16];

  always @(posedge clk) cyc <= cyc + 1;

  // ROM: data valid one cycle after the strobe.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rd_data <= rom[mem_addr];
      addr_log.push_back(mem_addr);
    end
  end

  always @(negedge clk) begin
    if (fc_valid_in) begin
      last_start = cyc;
      w255_log.push_back(fc_weights[255]);
      b15_log.push_back(fc_biases[15]);
    end
    if (timeout_err) begin tmo_cnt++; tmo_cyc = cyc; end
    if (out_valid) ov_cnt++;
  end

  function automatic logic [15:0][15:0] eng_compute(input logic [15:0][15:0] x,
      input logic [255:0][15:0] w, input logic [15:0][15:0] b);
    logic [15:0][15:0] y;
    int acc;
    for (int n = 0; n < 16; n++) begin
      acc = int'($signed(b[n]));
      for (int i = 0; i < 16; i++)
        acc += int'($signed(w[n*16+i])) * int'($signed(x[i]));
      y[n] = acc[15:0];
    end
    return y;
  endfunction

  // Engine stand-in: answers a start after eng_lat cycles with a done pulse,
  // or a level that stays high while eng_hold is set.
  initial begin
    fc_valid_out = 1'b0;
    fc_output = '0;
    forever begin
      @(posedge clk); #1;
      if (!eng_hold) fc_valid_out = 1'b0;
      if (fc_valid_in === 1'b1) begin
        repeat (eng_lat) begin @(posedge clk); #1; end
        fc_output = eng_compute(fc_input, fc_weights, fc_biases);
        fc_valid_out = 1'b1;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference MLP straight from the ROM image.
  function automatic void ref_run(input logic [15:0] xin [16], output logic [15:0][15:0] y,
      output int cls);
    logic [15:0] x [16];
    int acc;
    int base;
    x = xin;
    y = '0;
    for (int l = 0; l < NL; l++) begin
      base = l * 272;
      for (int n = 0; n < 16; n++) begin
        acc = int'($signed(rom[base+256+n]));
        for (int i = 0; i < 16; i++)
          acc += int'($signed(rom[base+n*16+i])) * int'($signed(x[i]));
        y[n] = acc[15:0];
      end
      if (l < NL - 1)
        for (int n = 0; n < 16; n++) x[n] = ($signed(y[n]) < 0) ? 16'd0 : y[n];
    end
    cls = 0;
    for (int n = 1; n < 16; n++) if ($signed(y[n]) > $signed(y[cls])) cls = n;
  endfunction

  // kind 0: identity, zero biases; 1: all zero; 2: random small values
  task automatic rom_layer(input int l, input int kind);
    for (int k = 0; k < 272; k++) begin
      case (kind)
        0: rom[l*272+k] = (k < 256 && (k / 16) == (k % 16)) ? 16'd1 : 16'd0;
        1: rom[l*272+k] = 16'd0;
        default: rom[l*272+k] = (k < 256) ? 16'(int'($urandom_range(0, 6)) - 3)
                                          : 16'(int'($urandom_range(0, 80)) - 40);
      endcase
    end
  endtask

  task automatic run_vec(input string tag, input int hold);
    logic [15:0][15:0] ey;
    int ecls, c0, n, drops;
    ref_run(xv, ey, ecls);
    for (int j = 0; j < 16; j++) in_vector[j] = xv[j];
    @(negedge clk);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    in_valid = 1'b1;
    c0 = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 4000) begin @(negedge clk); n++; end
    chk({tag, "_out_valid"}, out_valid, 1'b1);
    if (out_valid === 1'b1) begin
      // handshake cycle + per layer (LOAD 273, START, engine, CAPTURE) + ARGMAX 16
      chk({tag, "_latency"}, cyc - c0, 1 + NL * (273 + 1 + eng_lat + 1) + 16);
      chk({tag, "_vector"}, out_vector, ey);
      chk({tag, "_class"}, out_class, ecls);
      drops = 0;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (out_valid !== 1'b1 || out_vector !== ey || out_class !== 4'(ecls)) drops++;
      end
      if (hold > 0) chk({tag, "_hold_stable"}, drops, 0);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_out_valid_drop"}, out_valid, 1'b0);
      chk({tag, "_idle"}, in_ready, 1'b1);
    end
  endtask

  initial begin
    int n, t0, ov0, bad;
    for (int a = 0; a < 1024; a++) rom[a] = 16'd0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_fc_input", fc_input, '0);
    rstN = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1'b1);
    chk("post_rst_rd_en", mem_rd_en, 1'b0);

    // Identity through both layers, positive input passes unchanged.
    rom_layer(0, 0); rom_layer(1, 0);
    for (int j = 0; j < 16; j++) xv[j] = 16'(j + 1);
    run_vec("ident", 0);
    chk("ident_class15", out_class, 4'd15);
    chk("ident_out15", out_vector[15], 16'd16);

    // Layer 0 yields [-5,3,...]; ReLU zeroes -5; last layer stays raw.
    rom[256] = 16'hFFFA;
    rom[257] = 16'd1;
    rom[272+256+1] = 16'hFF9C;
    run_vec("relu", 0);
    chk("relu_out0_zero", out_vector[0], 16'd0);
    chk("relu_out1_raw", out_vector[1], 16'hFF9F);

    // All outputs equal 7: lowest index wins; result held 10 cycles.
    rom_layer(0, 2); rom_layer(1, 1);
    for (int k = 256; k < 272; k++) rom[272+k] = 16'd7;
    run_vec("tie", 10);
    chk("tie_class0", out_class, 4'd0);

    // ROM returns its address: check address sequence and loaded words.
    for (int a = 0; a < 1024; a++) rom[a] = 16'(a);
    addr_log.delete(); w255_log.delete(); b15_log.delete();
    eng_lat = 2;
    for (int j = 0; j < 16; j++) xv[j] = 16'(j % 3);
    run_vec("addr", 0);
    chk("addr_count", addr_log.size(), 2 * 272);
    bad = 0;
    foreach (addr_log[i]) if (addr_log[i] !== AW'(i)) bad++;
    chk("addr_sequence", bad, 0);
    chk("addr_starts", w255_log.size(), 2);
    if (w255_log.size() == 2) begin
      chk("addr_w255_l0", w255_log[0], 16'd255);
      chk("addr_w255_l1", w255_log[1], 16'd527);
      chk("addr_b15_l0", b15_log[0], 16'd271);
      chk("addr_b15_l1", b15_log[1], 16'd543);
    end

    // Randomized layers, inputs and engine latency.
    for (int r = 0; r < 3; r++) begin
      rom_layer(0, 2); rom_layer(1, 2);
      eng_lat = $urandom_range(1, 8);
      for (int j = 0; j < 16; j++) xv[j] = 16'(int'($urandom_range(0, 40)) - 20);
      run_vec($sformatf("rand%0d", r), $urandom_range(0, 3));
    end

    // Done level stuck high from layer 0: layer 1 must time out.
    rom_layer(0, 0); rom_layer(1, 0);
    eng_lat = 3;
    eng_hold = 1'b1;
    t0 = tmo_cnt;
    ov0 = ov_cnt;
    @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (tmo_cnt == t0 && n < 3000) begin @(negedge clk); n++; end
    chk("tmo_seen", tmo_cnt, t0 + 1);
    chk("tmo_after_wait", (tmo_cyc - last_start >= TMO) && (tmo_cyc - last_start <= TMO + 2), 1'b1);
    chk("tmo_in_ready", in_ready, 1'b1);
    chk("tmo_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    chk("tmo_single_pulse", tmo_cnt, t0 + 1);
    chk("tmo_no_output", ov_cnt, ov0);
    eng_hold = 1'b0;
    repeat (2) @(negedge clk);

    // Reset while loading layer 1, then a clean run.
    rom_layer(0, 2); rom_layer(1, 2);
    for (int j = 0; j < 16; j++) xv[j] = 16'(j);
    for (int j = 0; j < 16; j++) in_vector[j] = xv[j];
    @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!(mem_rd_en === 1'b1 && mem_addr >= AW'(330)) && n < 1500) begin @(negedge clk); n++; end
    chk("rst_mid_reached_l1", mem_addr >= AW'(330), 1'b1);
    rstN = 1'b0;
    #1;
    chk("rst_mid_in_ready", in_ready, 1'b1);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_rd_en", mem_rd_en, 1'b0);
    chk("rst_mid_addr", mem_addr, '0);
    chk("rst_mid_fc_input", fc_input, '0);
    chk("rst_mid_biases", fc_biases, '0);
    chk("rst_mid_weights_any", |fc_weights, 1'b0);
    chk("rst_mid_outs", {out_valid, fc_valid_in, timeout_err, out_class}, '0);
    chk("rst_mid_out_vector", out_vector, '0);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    for (int j = 0; j < 16; j++) xv[j] = 16'(int'($urandom_range(0, 30)) - 15);
    run_vec("after_rst", 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
